atconv_pool_seq: RTL and testbench
==================================

Name: atconv_pool_seq

Overview:
- Sequencer for the layer-1 stage of the ATCONV pipeline. It runs after layer 0 (the ReLU'd atrous-convolution map, 64x64, 13-bit) has been written to layer-0 memory.
- It owns the shared layer-memory port (csel/crd/cwr). For each output pixel it reads the 2x2 window from layer 0, takes the max, rounds it up to an integer, and writes the result to layer-1 memory (32x32).
- The top-level ATCONV FSM starts it with a pulse and waits for done.

Parameters:
- IMG_W, 64, layer-0 image width/height; power of 2, >=4.
- DW, 13, data width; fixed point with FRAC fraction bits.
- FRAC, 4, number of fraction bits in DW.
- AW, 12, layer-memory address width; must satisfy 2^AW >= IMG_W*IMG_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; starts a full pooling pass when idle.
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted, inclusive.
- done  output  1  one-cycle pulse after the last layer-1 write.
- csel  output  1  memory select: 0 = layer-0 memory, 1 = layer-1 memory.
- crd  output  1  read strobe.
- caddr_rd  output  AW  read address.
- cdata_rd  input  DW  read data; valid at the rising edge following the cycle in which crd/caddr_rd were driven.
- cwr  output  1  write strobe; memory captures the write on the rising edge ending that cycle.
- caddr_wr  output  AW  write address.
- cdata_wr  output  DW  write data.

Behaviour:
- Outputs:
  - All outputs are registered.
  - Reset drives every output to 0 and the FSM to IDLE immediately (asynchronous).
- Counter and addressing:
  - Output index idx runs 0..(IMG_W/2)^2-1.
  - r = idx / (IMG_W/2), c = idx % (IMG_W/2).
  - Window base A0 = 2r*IMG_W + 2c; A1 = A0+1; A2 = A0+IMG_W; A3 = A0+IMG_W+1.
- FSM states: IDLE, R0, R1, R2, R3, WR, DONE.
  - IDLE: all strobes 0. start=1 -> clear idx and max, go to R0, busy=1.
  - R0: csel=0, crd=1, caddr_rd=A0.
  - R1: max<=cdata_rd (A0 data); issue A1.
  - R2: max<=max(max,cdata_rd); issue A2.
  - R3: max<=max(max,cdata_rd); issue A3.
  - WR: crd=0, csel=1, cwr=1, caddr_wr=idx, cdata_wr=ceil(max(max,cdata_rd)). If idx is last -> DONE, else idx+1 -> R0.
  - DONE: cwr=0, csel=0, done=1, busy=0; next cycle IDLE.
- Throughput: 5 cycles per output. A full pass at IMG_W=64 is 5120 cycles from the first R0 to the last WR, inclusive.
- Arithmetic:
  - Max compare is unsigned; layer-0 data is post-ReLU and non-negative.
  - ceil: if fraction bits are 0, pass the value unchanged. Otherwise clear the fraction bits and add 2^FRAC.
  - If the rounded value would exceed DW bits, saturate to the largest integer value (all integer bits 1, fraction 0). At DW=13, FRAC=4 that is 0x1FF0.
- Port exclusivity:
  - crd and cwr are never high in the same cycle.
  - csel=1 only in WR.
- start handling:
  - start is ignored while busy or in DONE.
  - start coincident with reset deassertion is ignored; it must arrive at least one cycle after.
- Reset mid-operation:
  - Strobes drop to 0 at once; no partial write is issued.
  - idx is not retained; the next start restarts from idx 0.

Test Plan:
- Layer 0 all zero, pulse start -> 1024 writes of 0x0000 to layer-1 addresses 0..1023 in order; done pulses once; busy high for 5121 cycles.
- Window idx 0 = {0x0011, 0x0020, 0x001F, 0x0000} -> layer1[0] = 0x0020 (exact integer max, no round-up).
- Window idx 5 max 0x0021 -> layer1[5] = 0x0030; max 0x1FF8 at idx 7 -> layer1[7] = 0x1FF0 (saturated).
- Address trace: idx 33 reads 130, 131, 194, 195 (csel=0) then writes address 33 (csel=1); idx 1023 reads 4030, 4031, 4094, 4095. Assert crd and cwr are never high together.
- Assert reset while idx=500 in R2 -> crd, cwr, busy, csel go to 0 without waiting for a clock edge, and no write occurs. A new start rewrites from idx 0 and produces a correct full pass.
- Pulse start again at idx 10 -> ignored: no restart and no glitch on idx; done still comes after idx 1023.

Source files
------------

// File: rtl/atconv_pool_seq.sv
// Layer-1 sequencer for the ATCONV pipeline: 2x2 max-pool over the layer-0 map with
// round-up to integer, writing the pooled map into layer-1 memory over the shared port.
module atconv_pool_seq #(
  parameter int IMG_W = 64,
  parameter int DW    = 13,
  parameter int FRAC  = 4,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          csel,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr
);

  localparam int LW = $clog2(IMG_W);
  localparam int HB = LW - 1;
  localparam int IW = 2 * HB;
  localparam logic [2*LW-1:0] ROW_OFF = (2*LW)'(IMG_W);

  typedef enum logic [2:0] {IDLE, R0, R1, R2, R3, WR, DONE} state_t;

  state_t          state_reg;
  logic [IW-1:0]   idx_reg;
  logic [DW-1:0]   max_reg;
  logic            armed_reg;
  logic [2*LW-1:0] base;
  logic [DW-1:0]   max_next;

  // Window base 2r*IMG_W + 2c is just the row/column halves of idx with a zero inserted below each.
  assign base     = {idx_reg[IW-1:HB], 1'b0, idx_reg[HB-1:0], 1'b0};
  assign max_next = (cdata_rd > max_reg) ? cdata_rd : max_reg;

  function automatic logic [DW-1:0] ceil_int(input logic [DW-1:0] v);
    logic [DW-FRAC:0] ip;
    ip = {1'b0, v[DW-1:FRAC]} + (DW-FRAC+1)'(1);
    if (v[FRAC-1:0] == '0)
      return v;
    if (ip[DW-FRAC])
      return {{(DW-FRAC){1'b1}}, {FRAC{1'b0}}};
    return {ip[DW-FRAC-1:0], {FRAC{1'b0}}};
  endfunction

  // Outputs are registered on the way into the next state, so the memory sees each
  // read strobe one cycle after the state that requested it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      max_reg   <= '0;
      armed_reg <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      csel      <= 1'b0;
      crd       <= 1'b0;
      cwr       <= 1'b0;
      caddr_rd  <= '0;
      caddr_wr  <= '0;
      cdata_wr  <= '0;
    end else begin
      armed_reg <= 1'b1;
      done      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && armed_reg) begin
            idx_reg   <= '0;
            max_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= R0;
          end
        end
        R0: begin
          csel      <= 1'b0;
          cwr       <= 1'b0;
          crd       <= 1'b1;
          caddr_rd  <= AW'(base);
          state_reg <= R1;
        end
        R1: begin
          max_reg   <= cdata_rd;
          caddr_rd  <= AW'(base | (2*LW)'(1));
          state_reg <= R2;
        end
        R2: begin
          max_reg   <= max_next;
          caddr_rd  <= AW'(base | ROW_OFF);
          state_reg <= R3;
        end
        R3: begin
          max_reg   <= max_next;
          caddr_rd  <= AW'(base | ROW_OFF | (2*LW)'(1));
          state_reg <= WR;
        end
        WR: begin
          crd      <= 1'b0;
          csel     <= 1'b1;
          cwr      <= 1'b1;
          caddr_wr <= AW'(idx_reg);
          cdata_wr <= ceil_int(max_next);
          if (&idx_reg) begin
            state_reg <= DONE;
          end else begin
            idx_reg   <= idx_reg + IW'(1);
            state_reg <= R0;
          end
        end
        DONE: begin
          cwr       <= 1'b0;
          csel      <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atconv_pool_seq.sv
// Scoreboard bench for atconv_pool_seq: a behavioural model of the pooling pass predicts
// every read address and every layer-1 write, which the monitor checks as they appear.
module tb_atconv_pool_seq;
  localparam int IMG_W = 64;
  localparam int DW    = 13;
  localparam int FRAC  = 4;
  localparam int AW    = 12;
  localparam int NOUT  = (IMG_W / 2) * (IMG_W / 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done, csel, crd, cwr;
  logic [AW-1:0] caddr_rd, caddr_wr;
  logic [DW-1:0] cdata_rd, cdata_wr;

  logic [DW-1:0] mem0 [0:IMG_W*IMG_W-1];
  logic [DW-1:0] l1   [0:NOUT-1];

  int n_checks = 0;
  int n_errors = 0;
  int wr_count, done_count, busy_cycles;
  int exp_rd[$];
  int exp_wa[$];
  int exp_wd[$];

  always #5 clk = ~clk;

  atconv_pool_seq #(.IMG_W(IMG_W), .DW(DW), .FRAC(FRAC), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .csel(csel), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr)
  );

  // Layer-0 memory answers within the cycle the read strobe is presented.
  assign cdata_rd = (crd && !csel) ? mem0[caddr_rd] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ceil_model(input int v);
    int r;
    if (v % (1 << FRAC) == 0) return v;
    r = (v / (1 << FRAC) + 1) * (1 << FRAC);
    if (r > 'h1FF0) r = 'h1FF0;
    return r;
  endfunction

  task automatic push_expected();
    int r, c, a0, m;
    for (int i = 0; i < NOUT; i++) begin
      r  = i / (IMG_W / 2);
      c  = i % (IMG_W / 2);
      a0 = 2 * r * IMG_W + 2 * c;
      exp_rd.push_back(a0);
      exp_rd.push_back(a0 + 1);
      exp_rd.push_back(a0 + IMG_W);
      exp_rd.push_back(a0 + IMG_W + 1);
      m = int'(mem0[a0]);
      if (int'(mem0[a0 + 1]) > m)         m = int'(mem0[a0 + 1]);
      if (int'(mem0[a0 + IMG_W]) > m)     m = int'(mem0[a0 + IMG_W]);
      if (int'(mem0[a0 + IMG_W + 1]) > m) m = int'(mem0[a0 + IMG_W + 1]);
      exp_wa.push_back(i);
      exp_wd.push_back(ceil_model(m));
    end
  endtask

  always @(negedge clk) begin
    if (crd || cwr || csel) begin
      check("rd_wr_exclusive", {31'd0, crd & cwr}, 32'd0);
      check("csel_only_on_write", {31'd0, csel}, {31'd0, cwr});
    end
    if (crd) begin
      if (exp_rd.size() == 0) check("unexpected_read", 32'd1, 32'd0);
      else check("rd_addr", 32'(caddr_rd), exp_rd.pop_front());
    end
    if (cwr) begin
      if (exp_wa.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        check("wr_addr", 32'(caddr_wr), exp_wa.pop_front());
        check("wr_data", 32'(cdata_wr), exp_wd.pop_front());
      end
      l1[caddr_wr] = cdata_wr;
      wr_count++;
    end
    if (busy) busy_cycles++;
    if (done) begin
      done_count++;
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k;
    k = 0;
    while (wr_count < n && k < 6000) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, {31'd0, wr_count >= n}, 32'd1);
  endtask

  task automatic run_pass(input int pass_id, input bit restart_try);
    int k;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    wr_count = 0; done_count = 0; busy_cycles = 0;
    push_expected();
    pulse_start();
    if (restart_try) begin
      wait_writes(10, "reach_idx10");
      pulse_start();
    end
    k = 0;
    while (done_count == 0 && k < 6000) begin
      @(negedge clk); #1;
      k++;
    end
    check("done_seen", {31'd0, done_count > 0}, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("done_pulses", 32'(done_count), 32'd1);
    check("write_count", 32'(wr_count), NOUT);
    check("busy_cycles", 32'(busy_cycles), 32'd5121);
    check("reads_left", 32'(exp_rd.size()), 32'd0);
    check("writes_left", 32'(exp_wa.size()), 32'd0);
    $display("pass %0d: %0d writes, busy %0d cycles, done pulses %0d",
             pass_id, wr_count, busy_cycles, done_count);
  endtask

  task automatic fill_random();
    int v;
    for (int i = 0; i < IMG_W * IMG_W; i++) begin
      v = int'($urandom_range(0, 8191));
      if ($urandom_range(0, 1) == 1) v = v & ~15;
      mem0[i] = DW'(v);
    end
  endtask

  initial begin
    int k, held;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < IMG_W * IMG_W; i++) mem0[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_strobes", {29'd0, csel, crd, cwr}, 32'd0);
    check("rst_addr_rd", 32'(caddr_rd), 32'd0);
    check("rst_wdata", 32'(cdata_wr), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_pass(1, 1'b0);

    fill_random();
    mem0[0]  = 13'h0011; mem0[1]  = 13'h0020; mem0[64] = 13'h001F; mem0[65] = 13'h0000;
    mem0[10] = 13'h0021; mem0[11] = 13'h0010; mem0[74] = 13'h0005; mem0[75] = 13'h0020;
    mem0[14] = 13'h1FF8; mem0[15] = 13'h0100; mem0[78] = 13'h0000; mem0[79] = 13'h1FF0;
    run_pass(2, 1'b1);
    check("l1_idx0_exact", 32'(l1[0]), 32'h0020);
    check("l1_idx5_roundup", 32'(l1[5]), 32'h0030);
    check("l1_idx7_saturate", 32'(l1[7]), 32'h1FF0);

    // Abort a pass while idx 500 is reading its second word (R2).
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    wr_count = 0; done_count = 0; busy_cycles = 0;
    push_expected();
    pulse_start();
    wait_writes(500, "reach_idx500");
    k = 0;
    while (!(crd && caddr_rd == AW'(1961)) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("found_idx500_r2", {31'd0, crd && caddr_rd == AW'(1961)}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_strobes", {29'd0, csel, crd, cwr}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    held = wr_count;
    repeat (3) @(negedge clk);
    check("no_write_in_reset", 32'(wr_count), 32'(held));
    $display("reset at idx 500: %0d writes before abort", held);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();

    // Start raised on the same edge that reset is released must be ignored.
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    check("start_at_rst_release", {31'd0, busy}, 32'd0);

    fill_random();
    run_pass(3, 1'b0);
    check("l1_last_after_reset", 32'(l1[NOUT-1]),
          32'(ceil_model(int'(mem0[4030]) > int'(mem0[4031]) ?
                         (int'(mem0[4030]) > int'(mem0[4094]) ?
                          (int'(mem0[4030]) > int'(mem0[4095]) ? int'(mem0[4030]) : int'(mem0[4095])) :
                          (int'(mem0[4094]) > int'(mem0[4095]) ? int'(mem0[4094]) : int'(mem0[4095]))) :
                         (int'(mem0[4031]) > int'(mem0[4094]) ?
                          (int'(mem0[4031]) > int'(mem0[4095]) ? int'(mem0[4031]) : int'(mem0[4095])) :
                          (int'(mem0[4094]) > int'(mem0[4095]) ? int'(mem0[4094]) : int'(mem0[4095]))))));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
